// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the memory-port arbiter: FSM state encoding,
//   owner encoding, data widths and the registered memory command record.
//   No ports (package).
package mem_port_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Everything driven onto the memory port besides mem_req itself.
    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_cmd_t;

    // Command for the chosen owner. Fetches never write; loads carry a zero
    // strobe so memory sees byte enables only on stores.
    function automatic mem_cmd_t build_cmd(
        input logic              take_d,
        input logic [XLEN-1:0]   if_addr,
        input logic              d_we,
        input logic [XLEN-1:0]   d_addr,
        input logic [XLEN-1:0]   d_wdata,
        input logic [STRB_W-1:0] d_wstrb
    );
        mem_cmd_t c;
        if (take_d) begin
            c.we    = d_we;
            c.addr  = d_addr;
            c.wdata = d_wdata;
            c.wstrb = d_we ? d_wstrb : '0;
        end else begin
            c.we    = 1'b0;
            c.addr  = if_addr;
            c.wdata = '0;
            c.wstrb = '0;
        end
        return c;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog
//   Counts consecutive cycles spent in ACCESS and flags the cycle in which
//   the TIMEOUT-th such cycle is reached. TIMEOUT=0 disables the watchdog.
// Ports:
//   i_clk      system clock, rising edge
//   i_reset    synchronous active-high reset
//   i_run      high while the arbiter is in ACCESS
//   i_clear    restart the count (arbiter not in ACCESS)
//   o_expired  high during the last allowed ACCESS cycle
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic w_unused;
            assign w_unused  = ^{i_clk, i_reset, i_run, i_clear};
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            logic [CW-1:0] r_cnt;

            // The count holds the number of ACCESS cycles already completed,
            // so the current cycle is the TIMEOUT-th when it equals TIMEOUT-1.
            assign o_expired = i_run && (r_cnt == CW'(TIMEOUT - 1));

            always_ff @(posedge i_clk) begin
                if (i_reset || i_clear) begin
                    r_cnt <= '0;
                end else if (i_run && !o_expired) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (IF) and load/store (LSU).
//   IDLE picks an owner and registers its command, ACCESS holds mem_req until
//   mem_ready or watchdog expiry, DONE pulses the owner's ready for one cycle.
//   LSU has priority; after MAX_STREAK back-to-back LSU grants with IF waiting,
//   IF is granted next.
// Ports:
//   i_clk, i_reset                       clock, synchronous active-high reset
//   i_if_req/i_if_addr                   fetch request (held until o_if_ready)
//   o_if_ready/o_if_rdata                fetch completion pulse and data
//   i_d_req/i_d_we/i_d_addr/i_d_wdata/i_d_wstrb   LSU request (held until o_d_ready)
//   o_d_ready/o_d_rdata                  LSU completion pulse and load data
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata/o_mem_wstrb   memory command
//   i_mem_ready/i_mem_rdata              memory acknowledge and read data
//   o_err                                pulses with ready when the access aborted
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [XLEN-1:0]   i_if_addr,
    output logic              o_if_ready,
    output logic [XLEN-1:0]   o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [XLEN-1:0]   i_d_addr,
    input  logic [XLEN-1:0]   i_d_wdata,
    input  logic [STRB_W-1:0] i_d_wstrb,
    output logic              o_d_ready,
    output logic [XLEN-1:0]   o_d_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [STRB_W-1:0] o_mem_wstrb,
    input  logic              i_mem_ready,
    input  logic [XLEN-1:0]   i_mem_rdata,
    output logic              o_err
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    arb_state_t      r_state, w_state_nxt;
    owner_t          r_owner;
    mem_cmd_t        r_cmd;
    logic            r_mem_req;
    logic [3:0]      r_streak;
    logic            r_if_ready, r_d_ready, r_err;
    logic [XLEN-1:0] r_if_rdata, r_d_rdata;

    logic w_grant, w_take_d, w_complete, w_abort, w_expired;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_run     (r_state == ST_ACCESS),
        .i_clear   (r_state != ST_ACCESS),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_take_d    = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_if_req || i_d_req) begin
                    w_grant     = 1'b1;
                    w_take_d    = i_d_req && !(i_if_req && (r_streak == STREAK_MAX));
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // An acknowledge in the final allowed cycle still completes normally.
                if (i_mem_ready) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_owner    <= OWN_IF;
            r_cmd      <= '0;
            r_mem_req  <= 1'b0;
            r_streak   <= '0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_err      <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            // Ready/err are only ever set on the ACCESS->DONE edge, so they
            // naturally fall after the single DONE cycle.
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_err      <= 1'b0;

            if (w_grant) begin
                r_owner   <= w_take_d ? OWN_D : OWN_IF;
                r_cmd     <= build_cmd(w_take_d, i_if_addr, i_d_we, i_d_addr,
                                       i_d_wdata, i_d_wstrb);
                r_mem_req <= 1'b1;
                if (w_take_d && i_if_req) begin
                    if (r_streak != STREAK_MAX) r_streak <= r_streak + 4'd1;
                end else begin
                    r_streak <= '0;
                end
            end

            if (w_complete || w_abort) begin
                r_mem_req <= 1'b0;
                r_err     <= w_abort;
                if (r_owner == OWN_D) begin
                    r_d_ready <= 1'b1;
                    r_d_rdata <= w_abort ? '0 : i_mem_rdata;
                end else begin
                    r_if_ready <= 1'b1;
                    r_if_rdata <= w_abort ? '0 : i_mem_rdata;
                end
            end
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_cmd.we;
    assign o_mem_addr  = r_cmd.addr;
    assign o_mem_wdata = r_cmd.wdata;
    assign o_mem_wstrb = r_cmd.wstrb;
    assign o_if_ready  = r_if_ready;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_ready   = r_d_ready;
    assign o_d_rdata   = r_d_rdata;
    assign o_err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Randomized requesters and memory; a transaction-level model predicts each
//   grant (owner, command, access length, completion cycle, data, err) and a
//   separate monitor compares DUT behaviour against the predicted queues.
module tb_mem_port_arbiter;

    localparam int MAX_STREAK = 4;
    localparam int TIMEOUT    = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req, if_ready, d_req, d_we, d_ready;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb, mem_wstrb;
    logic        mem_req, mem_we, mem_ready, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_ready(if_ready), .o_if_rdata(if_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr),
        .i_d_wdata(d_wdata), .i_d_wstrb(d_wstrb),
        .o_d_ready(d_ready), .o_d_rdata(d_rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
        .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .o_err(err)
    );

    typedef struct {
        bit          is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          start;
        int          dur;
    } cmd_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
        int          at;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit go = 0, stop = 0, if_done = 0, d_done = 0;
    int n_if = 0, n_d = 0, n_abort = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model + memory responder. Sampled just after the falling edge,
    // so it sees exactly the inputs the DUT will sample at the next rising edge.
    initial begin : model
        int m_streak, m_free, m_ack, m_lo, m_hi, lat, dur;
        bit take_d, aborted;
        logic [31:0] m_val;
        cmd_t c;
        rsp_t r;
        m_streak = 0; m_free = 0; m_ack = -1; m_lo = 0; m_hi = -1;
        mem_ready = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk); #1;
            if (reset) begin
                m_streak = 0; m_free = 0; m_ack = -1; m_hi = -1;
                cmd_q.delete(); rsp_q.delete();
                mem_ready = 1'b0; mem_rdata = '0;
                continue;
            end
            // Memory: scheduled ack, or an occasional stray ack outside any access.
            if (cyc == m_ack) begin
                mem_ready = 1'b1; mem_rdata = m_val;
            end else if ((cyc <= m_lo || cyc > m_hi) && $urandom_range(7) == 0) begin
                mem_ready = 1'b1; mem_rdata = $urandom;
            end else begin
                mem_ready = 1'b0; mem_rdata = $urandom;
            end
            // Arbitration: free once the previous access' DONE cycle has passed.
            if (cyc >= m_free && (if_req || d_req)) begin
                take_d  = d_req && !(if_req && m_streak >= MAX_STREAK);
                lat     = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 10);
                aborted = (lat == 0) || (lat > TIMEOUT);
                dur     = aborted ? TIMEOUT : lat;
                m_val   = $urandom;
                if (take_d && if_req)
                    m_streak = (m_streak < MAX_STREAK) ? m_streak + 1 : MAX_STREAK;
                else
                    m_streak = 0;
                c.is_d  = take_d;
                c.we    = take_d ? d_we : 1'b0;
                c.addr  = take_d ? d_addr : if_addr;
                c.wdata = d_wdata;
                c.wstrb = (take_d && d_we) ? d_wstrb : 4'h0;
                c.start = cyc + 1;
                c.dur   = dur;
                cmd_q.push_back(c);
                r.is_d  = take_d;
                r.rdata = aborted ? 32'h0 : m_val;
                r.err   = aborted;
                r.at    = cyc + dur + 1;
                rsp_q.push_back(r);
                if (take_d) n_d++; else n_if++;
                if (aborted) n_abort++;
                m_ack  = (lat == 0) ? -1 : cyc + lat;
                m_lo   = cyc;
                m_hi   = cyc + dur;
                m_free = cyc + dur + 2;
            end
        end
    end

    // Monitor: compares what the DUT presents against the model's queues.
    initial begin : monitor
        bit   act, prev_rst, prev_req;
        int   len;
        cmd_t cur;
        rsp_t r;
        act = 0; prev_rst = 0; prev_req = 0; len = 0;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                chk("rst_mem_req", mem_req, 0);
                chk("rst_ready_err", {if_ready, d_ready, err}, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_we_strb", {mem_we, mem_wstrb}, 0);
                chk("rst_if_rdata", if_rdata, 0);
                chk("rst_d_rdata", d_rdata, 0);
            end
            if (mem_req && !prev_req) begin
                checks++;
                if (cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_mem_req: got mem_req=1, expected no access (cycle %0d)", cyc);
                    act = 0;
                end else begin
                    cur = cmd_q.pop_front();
                    chk("mem_req_start", cyc, cur.start);
                    act = 1; len = 0;
                end
            end
            if (mem_req && act) begin
                len++;
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_we", mem_we, cur.we);
                chk("mem_wstrb", mem_wstrb, cur.wstrb);
                if (cur.is_d) chk("mem_wdata", mem_wdata, cur.wdata);
            end
            if (!mem_req && prev_req && act) begin
                chk("mem_req_len", len, cur.dur);
                act = 0;
            end
            if (if_ready || d_ready) begin
                chk("ready_exclusive", {if_ready, d_ready} == 2'b11, 0);
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: got if_ready=%b d_ready=%b, expected none (cycle %0d)",
                             if_ready, d_ready, cyc);
                end else begin
                    r = rsp_q.pop_front();
                    chk("ready_owner", {if_ready, d_ready}, r.is_d ? 2'b01 : 2'b10);
                    chk("ready_cycle", cyc, r.at);
                    chk("rdata", r.is_d ? d_rdata : if_rdata, r.rdata);
                    chk("err", err, r.err);
                end
            end else begin
                chk("err_without_ready", err, 0);
            end
            prev_rst = reset;
            prev_req = mem_req;
            if (reset) act = 0;
        end
    end

    initial begin : drv_if
        bit got;
        if_req = 1'b0; if_addr = '0;
        wait (go);
        while (!stop) begin
            if ($urandom_range(1) == 1)
                repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            if_req  = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
            got = 0;
            for (int k = 0; k < 300 && !got; k++) begin
                @(negedge clk);
                got = if_ready;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL if_ready_wait: got no if_ready, expected one within 300 cycles");
            end
            @(posedge clk); #1;
            if_req = 1'b0;
        end
        if_done = 1;
    end

    initial begin : drv_d
        bit got;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        wait (go);
        while (!stop) begin
            if ($urandom_range(2) == 0)
                repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            d_req   = 1'b1;
            d_we    = $urandom_range(1) == 1;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom_range(1, 15));
            got = 0;
            for (int k = 0; k < 300 && !got; k++) begin
                @(negedge clk);
                got = d_ready;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL d_ready_wait: got no d_ready, expected one within 300 cycles");
            end
            @(posedge clk); #1;
            d_req = 1'b0;
        end
        d_done = 1;
    end

    initial begin : main
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        go = 1;
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(800, 1200)) @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
        end
        repeat (1000) @(posedge clk);
        #1 stop = 1;
        for (int k = 0; k < 2000 && !(if_done && d_done); k++) @(posedge clk);
        chk("drivers_finished", {if_done, d_done}, 2'b11);
        repeat (20) @(posedge clk);
        #1;
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("cmd_queue_drained", cmd_q.size(), 0);
        checks++;
        if (n_if == 0 || n_d == 0 || n_abort == 0) begin
            errors++;
            $display("FAIL traffic_mix: got if=%0d d=%0d aborts=%0d, expected all nonzero", n_if, n_d, n_abort);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
